// File: rtl/proc_perf_counters_pkg.sv
// Shared definitions for the processor performance counter block:
// default counter width, snapshot read-select map and FSM state type.
package proc_perf_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned NUM_CNT_DEF = 6;

    // Snapshot read-select map
    localparam logic [2:0] SEL_CYCLES = 3'd0;
    localparam logic [2:0] SEL_INST   = 3'd1;
    localparam logic [2:0] SEL_IREQ   = 3'd2;
    localparam logic [2:0] SEL_IHIT   = 3'd3;
    localparam logic [2:0] SEL_DREQ   = 3'd4;
    localparam logic [2:0] SEL_DHIT   = 3'd5;
    localparam logic [2:0] SEL_OVF    = 3'd6;
    localparam logic [2:0] SEL_STATUS = 3'd7;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } perfState_t;

endpackage

// File: rtl/proc_perf_counters_event.sv
// Single wrapping event counter with synchronous clear and sticky overflow.
// Exposes its next-state value so the owner can snapshot "after this edge".
module perf_event_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] nextCount,
    output logic             nextOvf
);

    logic [CNT_W-1:0] count;
    logic             ovf;

    // Next count/overflow: clear dominates, wrap at all-ones sets sticky ovf
    always_comb begin
        nextCount = count;
        nextOvf   = ovf;
        if (clr) begin
            nextCount = '0;
            nextOvf   = 1'b0;
        end else if (inc) begin
            nextCount = count + CNT_W'(1);
            if (count == '1) begin
                nextOvf = 1'b1;
            end
        end
    end

    // Register the counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= nextCount;
            ovf   <= nextOvf;
        end
    end

endmodule

// File: rtl/proc_perf_counters.sv
// Processor performance counters: cycle, retired-instruction and I/D-cache
// request/hit counts gathered from WB/MEM strobes, frozen on halt, read
// back through an atomically loaded snapshot bank.
module proc_perf_counters
    import proc_perf_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NUM_CNT = NUM_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             clr,
    input  logic             snap,
    output logic             snap_done,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             halted
);

    perfState_t       state;
    perfState_t       nextState;
    logic             protoErr;
    logic             nextProto;
    logic             running;
    logic [NUM_CNT-1:0] evt;
    logic [NUM_CNT-1:0] nextOvf;
    logic [CNT_W-1:0] nextCnt [NUM_CNT];

    logic [CNT_W-1:0] snapCnt [NUM_CNT];
    logic [NUM_CNT-1:0] snapOvf;
    logic             snapProto;
    logic             snapHalted;
    logic [CNT_W-1:0] rdNext;

    // Event strobes: only counted in RUN, and a clear drops the cycle's events
    always_comb begin
        running          = (state == RUN) && !clr;
        evt              = '0;
        evt[SEL_CYCLES]  = running;
        evt[SEL_INST]    = running && (reg_write || mem_write || halt);
        evt[SEL_IREQ]    = running && icache_req;
        evt[SEL_IHIT]    = running && icache_req && icache_hit;
        evt[SEL_DREQ]    = running && dcache_req;
        evt[SEL_DHIT]    = running && dcache_req && dcache_hit;
    end

    // Next FSM state and protocol-error flag (needed early for the snapshot)
    always_comb begin
        nextState = state;
        nextProto = protoErr;
        if (clr) begin
            nextState = RUN;
            nextProto = 1'b0;
        end else if (state == RUN) begin
            if (halt) begin
                nextState = HALTED;
            end
            if ((icache_hit && !icache_req) || (dcache_hit && !dcache_req)) begin
                nextProto = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : gCnt
            perf_event_counter #(.CNT_W(CNT_W)) uCnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (evt[g]),
                .clr       (clr),
                .nextCount (nextCnt[g]),
                .nextOvf   (nextOvf[g])
            );
        end
    endgenerate

    // FSM with registered halted/snap_done outputs and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            halted    <= 1'b0;
            protoErr  <= 1'b0;
            snap_done <= 1'b0;
        end else begin
            state     <= nextState;
            halted    <= (nextState == HALTED);
            protoErr  <= nextProto;
            snap_done <= snap;
        end
    end

    // Snapshot bank: captures post-edge values, so clr+snap loads zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                snapCnt[i] <= '0;
            end
            snapOvf    <= '0;
            snapProto  <= 1'b0;
            snapHalted <= 1'b0;
        end else if (snap) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                snapCnt[i] <= nextCnt[i];
            end
            snapOvf    <= nextOvf;
            snapProto  <= nextProto;
            snapHalted <= (nextState == HALTED);
        end
    end

    // Read mux over the snapshot bank only; status words are zero-extended
    always_comb begin
        rdNext = '0;
        case (rd_sel)
            SEL_CYCLES: rdNext = snapCnt[0];
            SEL_INST:   rdNext = snapCnt[1];
            SEL_IREQ:   rdNext = snapCnt[2];
            SEL_IHIT:   rdNext = snapCnt[3];
            SEL_DREQ:   rdNext = snapCnt[4];
            SEL_DHIT:   rdNext = snapCnt[5];
            SEL_OVF:    rdNext = CNT_W'(snapOvf);
            SEL_STATUS: rdNext = CNT_W'({snapProto, snapHalted});
            default:    rdNext = '0;
        endcase
    end

    // Registered read data, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rdNext;
        end
    end

endmodule

// File: tb/tb_proc_perf_counters.sv
// Directed testbench for proc_perf_counters: a 32-bit instance for the
// main counting/halt/clear behaviour and a 4-bit instance for wrap/overflow.
module tb_proc_perf_counters;

    logic        clk = 1'b0;
    logic        rstN;
    logic        regWrite, memWrite, halt;
    logic        icacheReq, icacheHit, dcacheReq, dcacheHit;
    logic        clr, snap;
    logic [2:0]  rdSel;
    logic        snapDone, halted;
    logic [31:0] rdData;

    logic        sIdle;
    logic        sClr, sSnap;
    logic [2:0]  sRdSel;
    logic        sSnapDone, sHalted;
    logic [3:0]  sRdData;

    int unsigned nVec = 0;
    int unsigned nErr = 0;

    always #5 clk = ~clk;

    proc_perf_counters uDut (
        .clk        (clk),
        .rst_n      (rstN),
        .reg_write  (regWrite),
        .mem_write  (memWrite),
        .halt       (halt),
        .icache_req (icacheReq),
        .icache_hit (icacheHit),
        .dcache_req (dcacheReq),
        .dcache_hit (dcacheHit),
        .clr        (clr),
        .snap       (snap),
        .snap_done  (snapDone),
        .rd_sel     (rdSel),
        .rd_data    (rdData),
        .halted     (halted)
    );

    proc_perf_counters #(.CNT_W(4)) uSmall (
        .clk        (clk),
        .rst_n      (rstN),
        .reg_write  (sIdle),
        .mem_write  (sIdle),
        .halt       (sIdle),
        .icache_req (sIdle),
        .icache_hit (sIdle),
        .dcache_req (sIdle),
        .dcache_hit (sIdle),
        .clr        (sClr),
        .snap       (sSnap),
        .snap_done  (sSnapDone),
        .rd_sel     (sRdSel),
        .rd_data    (sRdData),
        .halted     (sHalted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic readSel(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        rdSel = sel;
        tick();
        check(tag, rdData, exp);
    endtask

    task automatic readSmall(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        sRdSel = sel;
        tick();
        check(tag, {28'd0, sRdData}, exp);
    endtask

    initial begin
        rstN = 1'b0;
        {regWrite, memWrite, halt, icacheReq, icacheHit, dcacheReq, dcacheHit} = '0;
        {clr, snap, sIdle, sClr, sSnap} = '0;
        rdSel  = 3'd0;
        sRdSel = 3'd0;

        // Reset state
        repeat (2) tick();
        check("rst_rd_data", rdData, 32'd0);
        check("rst_snap_done", {31'd0, snapDone}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rstN = 1'b1;

        // 10 RUN cycles: 4 reg_write, 8 ireq/5 hit, 3 dreq/1 hit, snap on the 10th
        for (int i = 0; i < 10; i++) begin
            regWrite  = (i < 4);
            icacheReq = (i < 8);
            icacheHit = (i < 5);
            dcacheReq = (i < 3);
            dcacheHit = (i < 1);
            snap      = (i == 9);
            tick();
        end
        {regWrite, icacheReq, icacheHit, dcacheReq, dcacheHit, snap} = '0;
        check("snap_done_pulse", {31'd0, snapDone}, 32'd1);
        readSel(3'd0, 32'd10, "cycles10");
        check("snap_done_drop", {31'd0, snapDone}, 32'd0);
        readSel(3'd1, 32'd4, "inst4");
        readSel(3'd2, 32'd8, "ireq8");
        readSel(3'd3, 32'd5, "ihit5");
        readSel(3'd4, 32'd3, "dreq3");
        readSel(3'd5, 32'd1, "dhit1");
        readSel(3'd6, 32'd0, "ovf0");
        readSel(3'd7, 32'd0, "status0");

        // Halt on cycle 20 after clear, then 5 frozen cycles of reg_write
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (19) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        regWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            snap = (i == 4);
            tick();
        end
        {regWrite, snap} = '0;
        check("halted_set", {31'd0, halted}, 32'd1);
        readSel(3'd0, 32'd20, "halt_cycles20");
        readSel(3'd1, 32'd1, "halt_inst1");
        readSel(3'd7, 32'd1, "halt_status");

        // Clear leaves HALTED; hit without request flags proto_err
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_unhalt", {31'd0, halted}, 32'd0);
        dcacheHit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            snap = (i == 2);
            tick();
        end
        {dcacheHit, snap} = '0;
        readSel(3'd0, 32'd3, "proto_cycles3");
        readSel(3'd5, 32'd0, "proto_dhit0");
        readSel(3'd7, 32'd2, "proto_status");

        // clr and snap in the same cycle after activity
        regWrite = 1'b1; icacheReq = 1'b1;
        repeat (4) tick();
        clr = 1'b1; snap = 1'b1; tick();
        {clr, snap, regWrite, icacheReq} = '0;
        check("clrsnap_done", {31'd0, snapDone}, 32'd1);
        readSel(3'd0, 32'd0, "clrsnap_cycles");
        readSel(3'd1, 32'd0, "clrsnap_inst");
        readSel(3'd2, 32'd0, "clrsnap_ireq");
        readSel(3'd7, 32'd0, "clrsnap_status");

        // clr and halt in the same cycle: stays in RUN, halt event dropped
        clr = 1'b1; halt = 1'b1; tick();
        clr = 1'b0; halt = 1'b0;
        check("clrhalt_run", {31'd0, halted}, 32'd0);
        snap = 1'b1; tick(); snap = 1'b0;
        readSel(3'd0, 32'd1, "clrhalt_cycles");
        readSel(3'd1, 32'd0, "clrhalt_inst");

        // 4-bit instance: 17 cycles after clear wraps cycles to 1 with ovf[0]
        sClr = 1'b1; tick(); sClr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sSnap = (i == 16);
            tick();
        end
        sSnap = 1'b0;
        readSmall(3'd0, 32'd1, "wrap_cycles1");
        readSmall(3'd6, 32'd1, "wrap_ovf");
        readSmall(3'd1, 32'd0, "wrap_inst0");
        sClr = 1'b1; tick(); sClr = 1'b0;
        sSnap = 1'b1; tick(); sSnap = 1'b0;
        readSmall(3'd0, 32'd1, "postclr_cycles");
        readSmall(3'd6, 32'd0, "postclr_ovf");
        check("small_halted", {31'd0, sHalted}, 32'd0);

        // Back-to-back snaps into HALTED, then asynchronous reset mid-cycle
        rdSel = 3'd0;
        clr = 1'b1; tick(); clr = 1'b0;
        halt = 1'b1; snap = 1'b1; tick();
        halt = 1'b0; tick();
        snap = 1'b0;
        check("b2b_snap_done", {31'd0, snapDone}, 32'd1);
        check("b2b_halted", {31'd0, halted}, 32'd1);
        check("b2b_rd_data", rdData, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_rd_data", rdData, 32'd0);
        check("arst_snap_done", {31'd0, snapDone}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_small_rd", {28'd0, sRdData}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
